// File: rtl/vga_scanout.sv
// vga_scanout: streams a frame held in CORES_COUNT PPU memories as
// Avalon-ST pixels, double-buffered with a swap request at frame end.
// Ports: clk, rst (async, active-high)
//   m_data/m_startofpacket/m_endofpacket/m_valid/m_ready : pixel stream
//   raddress/rselect/rdata : fixed-latency memory read port
//   swap_req/buf_sel : front-buffer toggle, frame_done : eop accepted
module vga_scanout #(
   parameter int VGA_WIDTH     = 800,
   parameter int VGA_HEIGHT    = 600,
   parameter int CORES_COUNT   = 10,
   parameter int R_W           = 5,
   parameter int G_W           = 6,
   parameter int B_W           = 5,
   parameter int BUFFER_ADDR_W = 32,
   parameter int FIFO_DEPTH_W  = 3,
   parameter int RD_LATENCY    = 1,
   parameter int INTERLEAVE    = 0
) (
   input  logic clk,
   input  logic rst,
   output logic [29:0] m_data,
   output logic m_startofpacket,
   output logic m_endofpacket,
   output logic m_valid,
   input  logic m_ready,
   output logic [BUFFER_ADDR_W-1:0] raddress,
   output logic [(CORES_COUNT > 1 ? $clog2(CORES_COUNT) : 1)-1:0] rselect,
   input  logic [R_W+G_W+B_W-1:0] rdata,
   input  logic swap_req,
   output logic buf_sel,
   output logic frame_done
);

   localparam int CW = R_W + G_W + B_W;
   localparam int LINES = VGA_HEIGHT / CORES_COUNT;
   localparam int DEPTH = 2 ** FIFO_DEPTH_W;
   localparam int FRAME_WORDS = (VGA_WIDTH * VGA_HEIGHT) / CORES_COUNT;
   localparam int XW = VGA_WIDTH > 1 ? $clog2(VGA_WIDTH) : 1;
   localparam int YW = VGA_HEIGHT > 1 ? $clog2(VGA_HEIGHT) : 1;
   localparam int SW = CORES_COUNT > 1 ? $clog2(CORES_COUNT) : 1;
   localparam int LW = LINES > 1 ? $clog2(LINES) : 1;
   localparam int UW = FIFO_DEPTH_W + 1;
   localparam int RR = (10 + R_W - 1) / R_W;
   localparam int GR = (10 + G_W - 1) / G_W;
   localparam int BR = (10 + B_W - 1) / B_W;

   generate
      if (VGA_HEIGHT % CORES_COUNT != 0) begin : g_bad_height
         $error("VGA_HEIGHT must be a multiple of CORES_COUNT");
      end
      if (R_W < 1 || R_W > 10 || G_W < 1 || G_W > 10 || B_W < 1 || B_W > 10) begin : g_bad_chan
         $error("channel widths must be 1..10");
      end
      if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
         $error("RD_LATENCY must be 1..4");
      end
   endgenerate

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [SW-1:0] sel;
   logic [LW-1:0] lline;
   logic [BUFFER_ADDR_W-1:0] line_base;
   logic pending;
   logic [UW-1:0] used;
   logic [RD_LATENCY-1:0] sr_v, sr_sop, sr_eop;
   logic [CW+1:0] mem [DEPTH];
   logic [FIFO_DEPTH_W-1:0] wr_ptr, rd_ptr;
   logic [UW-1:0] cnt;
   logic [CW+1:0] head;
   logic issue, first, last, push, pop;
   logic [RR*R_W-1:0] r_rep;
   logic [GR*G_W-1:0] g_rep;
   logic [BR*B_W-1:0] b_rep;

   // Reads in flight plus FIFO occupancy never exceed the FIFO depth.
   assign issue = used < UW'(DEPTH);
   assign first = (x == '0) && (y == '0);
   assign last = (x == XW'(VGA_WIDTH - 1)) && (y == YW'(VGA_HEIGHT - 1));
   assign push = sr_v[RD_LATENCY-1];
   assign pop = m_valid && m_ready;

   assign raddress = (buf_sel ? BUFFER_ADDR_W'(FRAME_WORDS) : '0)
                   + line_base + BUFFER_ADDR_W'(x);
   assign rselect = sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
         sel <= '0;
         lline <= '0;
         line_base <= '0;
      end else if (issue) begin
         if (x == XW'(VGA_WIDTH - 1)) begin
            x <= '0;
            if (y == YW'(VGA_HEIGHT - 1)) begin
               y <= '0;
               sel <= '0;
               lline <= '0;
               line_base <= '0;
            end else begin
               y <= y + YW'(1);
               if (INTERLEAVE == 0) begin
                  // band: a memory holds LINES consecutive lines
                  if (lline == LW'(LINES - 1)) begin
                     lline <= '0;
                     line_base <= '0;
                     sel <= sel + SW'(1);
                  end else begin
                     lline <= lline + LW'(1);
                     line_base <= line_base + BUFFER_ADDR_W'(VGA_WIDTH);
                  end
               end else begin
                  // line: memories take turns line by line
                  if (sel == SW'(CORES_COUNT - 1)) begin
                     sel <= '0;
                     lline <= lline + LW'(1);
                     line_base <= line_base + BUFFER_ADDR_W'(VGA_WIDTH);
                  end else begin
                     sel <= sel + SW'(1);
                  end
               end
            end
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_sel <= 1'b0;
         pending <= 1'b0;
      end else if (issue && last) begin
         if (pending || swap_req) buf_sel <= ~buf_sel;
         pending <= 1'b0;
      end else if (swap_req) begin
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_v <= '0;
         sr_sop <= '0;
         sr_eop <= '0;
      end else begin
         sr_v[0] <= issue;
         sr_sop[0] <= issue && first;
         sr_eop[0] <= issue && last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            sr_v[i] <= sr_v[i-1];
            sr_sop[i] <= sr_sop[i-1];
            sr_eop[i] <= sr_eop[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {sr_sop[RD_LATENCY-1], sr_eop[RD_LATENCY-1], rdata};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
         used <= '0;
         frame_done <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_W'(1);
         if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_W'(1);
         cnt <= cnt + UW'(push) - UW'(pop);
         used <= used + UW'(issue) - UW'(pop);
         frame_done <= pop && m_endofpacket;
      end
   end

   assign head = mem[rd_ptr];
   assign m_valid = cnt != '0;
   assign m_startofpacket = m_valid && head[CW+1];
   assign m_endofpacket = m_valid && head[CW];

   // Repeat each channel and keep the top 10 bits: MSB-aligned with
   // the low bits refilled from the channel's own MSBs.
   assign r_rep = {RR{head[CW-1 -: R_W]}};
   assign g_rep = {GR{head[G_W+B_W-1 -: G_W]}};
   assign b_rep = {BR{head[B_W-1:0]}};
   assign m_data = m_valid ? {r_rep[RR*R_W-1 -: 10],
                              g_rep[GR*G_W-1 -: 10],
                              b_rep[BR*B_W-1 -: 10]} : '0;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout at 4x4, 2 cores,
// read latency 2; band-mode and line-mode instances share stimulus.
module tb_vga_scanout;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_ready = 1'b0;
   logic swap_req = 1'b0;
   logic ovr = 1'b0;
   logic [15:0] ovr_col = '0;

   logic [29:0] data0, data1;
   logic sop0, eop0, val0, sop1, eop1, val1;
   logic [31:0] radr0, radr1;
   logic [0:0] rsel0, rsel1;
   logic [15:0] rdata0, rdata1;
   logic buf0, buf1, fd_pulse0, fd_pulse1;
   logic [15:0] p0a, p0b, p1a, p1b;

   int checks = 0;
   int errs = 0;
   int fd0 = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk = ~clk;

   vga_scanout #(
      .VGA_WIDTH(4), .VGA_HEIGHT(4), .CORES_COUNT(2),
      .R_W(5), .G_W(6), .B_W(5), .BUFFER_ADDR_W(32),
      .FIFO_DEPTH_W(3), .RD_LATENCY(2), .INTERLEAVE(0)
   ) dut0 (
      .clk(clk), .rst(rst), .m_data(data0),
      .m_startofpacket(sop0), .m_endofpacket(eop0),
      .m_valid(val0), .m_ready(m_ready),
      .raddress(radr0), .rselect(rsel0), .rdata(rdata0),
      .swap_req(swap_req), .buf_sel(buf0), .frame_done(fd_pulse0)
   );

   vga_scanout #(
      .VGA_WIDTH(4), .VGA_HEIGHT(4), .CORES_COUNT(2),
      .R_W(5), .G_W(6), .B_W(5), .BUFFER_ADDR_W(32),
      .FIFO_DEPTH_W(3), .RD_LATENCY(2), .INTERLEAVE(1)
   ) dut1 (
      .clk(clk), .rst(rst), .m_data(data1),
      .m_startofpacket(sop1), .m_endofpacket(eop1),
      .m_valid(val1), .m_ready(m_ready),
      .raddress(radr1), .rselect(rsel1), .rdata(rdata1),
      .swap_req(swap_req), .buf_sel(buf1), .frame_done(fd_pulse1)
   );

   function automatic logic [15:0] pat(input logic s, input logic [3:0] a);
      return {s, a, a, 2'b10, ~s, ~a};
   endfunction

   function automatic logic [9:0] ex(input logic [9:0] ch, input int w);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[9-i] = ch[w-1-(i%w)];
      return r;
   endfunction

   function automatic logic [29:0] expand16(input logic [15:0] c);
      return {ex(10'(c[15:11]), 5), ex(10'(c[10:5]), 6), ex(10'(c[4:0]), 5)};
   endfunction

   function automatic logic [31:0] exp_beat(input int b, input int p, input int mode);
      int xx, yy, s, loc, a;
      xx = p % 4;
      yy = p / 4;
      s = (mode == 0) ? yy / 2 : yy % 2;
      loc = (mode == 0) ? yy % 2 : yy / 2;
      a = b * 8 + loc * 4 + xx;
      return {p == 0, p == 15, expand16(pat(s[0], a[3:0]))};
   endfunction

   // Memory model: returns the tagged word two clocks after the address.
   always @(posedge clk) begin
      p0a <= ovr ? ovr_col : pat(rsel0[0], radr0[3:0]);
      p0b <= p0a;
      p1a <= ovr ? ovr_col : pat(rsel1[0], radr1[3:0]);
      p1b <= p1a;
   end
   assign rdata0 = p0b;
   assign rdata1 = p1b;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         q0.delete();
         q1.delete();
         fd0 = 0;
      end else begin
         if (val0 && m_ready) q0.push_back({sop0, eop0, data0});
         if (val1 && m_ready) q1.push_back({sop1, eop1, data1});
         if (fd_pulse0) fd0++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_q(input int n, input string nm);
      int k = 0;
      while (q0.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (q0.size() < n) begin
         checks++;
         errs++;
         $display("FAIL %s timeout actual=%0d required=%0d", nm, q0.size(), n);
      end
   endtask

   task automatic wait_px(input logic s, input logic [31:0] a, input string nm);
      int k = 0;
      while (!(rsel0[0] == s && radr0 == a) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) begin
         checks++;
         errs++;
         $display("FAIL %s timeout waiting for sel=%0d addr=%0d", nm, s, a);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      string nm;
      logic [15:0] col;
      logic [29:0] exp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [29:0] held;
      int stable;

      tbl[0] = '{"mag", 16'hF81F, {10'h3FF, 10'h000, 10'h3FF}};
      tbl[1] = '{"black", 16'h0000, {10'h000, 10'h000, 10'h000}};
      tbl[2] = '{"white", 16'hFFFF, {10'h3FF, 10'h3FF, 10'h3FF}};
      tbl[3] = '{"g20", 16'h0400, {10'h000, 10'h208, 10'h000}};
      tbl[4] = '{"r10", 16'h8000, {10'h210, 10'h000, 10'h000}};
      tbl[5] = '{"b01g01", 16'h0021, {10'h000, 10'h010, 10'h021}};
      tbl[6] = '{"alt", 16'hAD4A, {10'h2B5, 10'h2AA, 10'h14A}};

      @(negedge clk);
      #1;
      chk("rst_valid", 64'(val0), 64'd0);
      chk("rst_flags", 64'({sop0, eop0, fd_pulse0, buf0}), 64'd0);
      chk("rst_data", 64'(data0), 64'd0);
      chk("rst_addr", 64'({rsel0, radr0}), 64'd0);

      // Colour expansion, one frame start per vector
      m_ready = 1'b1;
      ovr = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ovr_col = tbl[i].col;
         do_reset();
         wait_q(1, tbl[i].nm);
         chk(tbl[i].nm, 64'(q0[0]), 64'({2'b10, tbl[i].exp}));
      end
      ovr = 1'b0;

      // Full-rate frame, band and line order
      do_reset();
      wait_q(16, "frame_band");
      for (int p = 0; p < 16; p++) begin
         chk($sformatf("band_px%0d", p), 64'(q0[p]), 64'(exp_beat(0, p, 0)));
         chk($sformatf("line_px%0d", p), 64'(q1[p]), 64'(exp_beat(0, p, 1)));
      end
      repeat (3) @(negedge clk);
      chk("frame_done_once", 64'(fd0), 64'd1);

      // Back-pressure: fetch stops at pixel 8, head beat held
      m_ready = 1'b0;
      do_reset();
      repeat (10) @(negedge clk);
      held = data0;
      stable = 1;
      repeat (10) begin
         @(negedge clk);
         if (data0 !== held || sop0 !== 1'b1 || val0 !== 1'b1) stable = 0;
      end
      chk("stall_stable", 64'(stable), 64'd1);
      chk("stall_head", 64'({sop0, eop0, data0}), 64'(exp_beat(0, 0, 0)));
      chk("stall_fetch_pos", 64'({rsel0, radr0}), 64'({1'b1, 32'd0}));
      m_ready = 1'b1;
      wait_q(16, "stall_release");
      for (int p = 0; p < 16; p++)
         chk($sformatf("stall_px%0d", p), 64'(q0[p]), 64'(exp_beat(0, p, 0)));

      // Buffer swap at frame end, second request ignored
      do_reset();
      repeat (3) @(negedge clk);
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      repeat (4) @(negedge clk);
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      wait_px(1'b1, 32'd7, "swap_last_px");
      chk("swap_buf_pre", 64'(buf0), 64'd0);
      @(negedge clk);
      chk("swap_buf_post", 64'(buf0), 64'd1);
      chk("swap_addr_post", 64'({rsel0, radr0}), 64'({1'b0, 32'd8}));
      wait_q(32, "swap_frames");
      for (int p = 0; p < 16; p++)
         chk($sformatf("swap_px%0d", p), 64'(q0[16+p]), 64'(exp_beat(1, p, 0)));
      wait_px(1'b1, 32'd15, "swap_hold_px");
      @(negedge clk);
      chk("swap_buf_hold", 64'(buf0), 64'd1);
      chk("frame_done_two", 64'(fd0), 64'd2);

      // Reset with a full FIFO while the back buffer is selected
      m_ready = 1'b0;
      repeat (12) @(negedge clk);
      chk("full_valid", 64'(val0), 64'd1);
      chk("full_buf", 64'(buf0), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(val0), 64'd0);
      chk("midrst_out", 64'({sop0, eop0, fd_pulse0, buf0, data0}), 64'd0);
      chk("midrst_addr", 64'({rsel0, radr0}), 64'd0);
      repeat (2) @(negedge clk);
      m_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("post_rst_fetch", 64'({buf0, rsel0, radr0}), 64'd0);
      @(negedge clk);
      wait_q(16, "post_rst");
      for (int p = 0; p < 16; p++)
         chk($sformatf("post_rst_px%0d", p), 64'(q0[p]), 64'(exp_beat(0, p, 0)));

      // Request landing on the last-pixel cycle still toggles
      wait_px(1'b1, 32'd7, "late_swap_px");
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      chk("late_swap_buf", 64'(buf0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
